pipe_stage_regs: RTL and testbench

//   Decode/execute/writeback pipeline register chain of the CPU, sitting between the

---
 rtl/pipe_stage_regs_if.sv | 61 ++++++
 rtl/pipe_stage_regs.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_regs.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_regs_if.sv
// Purpose: bundles the decoder fields, control-unit enables and the stage outputs
//          of the decode/execute/writeback register chain.
// Signals:
//   decoder side : in_A, in_B, in_C, in_T, in_ALU, in_MR, in_valid
//   control side : en0, en1, flush (in); fetch_en (out, combinational)
//   stage fields : A0,B0,C0,T0,ALU0,MR0,v0 / C1,T1,ALU1,v1 / C2,T2,v2
//   counters     : stall_cnt, bubble_cnt
// Modports: master = decoder/control/testbench side, slave = pipe_stage_regs.
interface pipe_stage_regs_if #(
    parameter int unsigned CW   = 6,
    parameter int unsigned BW   = 5,
    parameter int unsigned TW   = 7,
    parameter int unsigned ALUW = 4,
    parameter int unsigned CNTW = 16
);
    // decoded instruction
    logic [CW-1:0]   in_A;
    logic [BW-1:0]   in_B;
    logic [CW-1:0]   in_C;
    logic [TW-1:0]   in_T;
    logic [ALUW-1:0] in_ALU;
    logic            in_MR;
    logic            in_valid;
    // control unit
    logic            en0;
    logic            en1;
    logic            flush;
    logic            fetch_en;
    // stage 0
    logic [CW-1:0]   A0;
    logic [BW-1:0]   B0;
    logic [CW-1:0]   C0;
    logic [TW-1:0]   T0;
    logic [ALUW-1:0] ALU0;
    logic            MR0;
    logic            v0;
    // stage 1
    logic [CW-1:0]   C1;
    logic [TW-1:0]   T1;
    logic [ALUW-1:0] ALU1;
    logic            v1;
    // stage 2
    logic [CW-1:0]   C2;
    logic [TW-1:0]   T2;
    logic            v2;
    // performance counters
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] bubble_cnt;

    modport master (
        output in_A, in_B, in_C, in_T, in_ALU, in_MR, in_valid, en0, en1, flush,
        input  fetch_en, A0, B0, C0, T0, ALU0, MR0, v0, C1, T1, ALU1, v1,
               C2, T2, v2, stall_cnt, bubble_cnt
    );

    modport slave (
        input  in_A, in_B, in_C, in_T, in_ALU, in_MR, in_valid, en0, en1, flush,
        output fetch_en, A0, B0, C0, T0, ALU0, MR0, v0, C1, T1, ALU1, v1,
               C2, T2, v2, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_regs.sv
// Purpose: three-stage (decode/execute/writeback) pipeline register chain. Holds
//          stalled stages, inserts bubbles on stall/flush and counts stall and
//          bubble cycles with saturating counters.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, every stage becomes a bubble
//   bus  - pipe_stage_regs_if.slave: decoder fields in, en0/en1/flush in,
//          stage fields and counters out (registered), fetch_en out (combinational)
module pipe_stage_regs #(
    parameter int unsigned CW   = 6,
    parameter int unsigned BW   = 5,
    parameter int unsigned TW   = 7,
    parameter int unsigned ALUW = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stage_regs_if.slave   bus
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [CW-1:0]   a;
        logic [BW-1:0]   b;
        logic [CW-1:0]   c;
        logic [TW-1:0]   t;
        logic [ALUW-1:0] alu;
        logic            mr;
        logic            v;
    } s0_t;

    typedef struct packed {
        logic [CW-1:0]   c;
        logic [TW-1:0]   t;
        logic [ALUW-1:0] alu;
        logic            v;
    } s1_t;

    typedef struct packed {
        logic [CW-1:0]   c;
        logic [TW-1:0]   t;
        logic            v;
    } s2_t;

    s0_t             s0_q, s0_d;
    s1_t             s1_q, s1_d;
    s2_t             s2_q, s2_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic [CNTW-1:0] bubble_q, bubble_d;

    logic            adv0;
    logic            s0_pass;

    // stage 0 moves on only when both enables are up; stage 1 takes stage 0 unless flushed
    assign adv0    = bus.en0 & bus.en1;
    assign s0_pass = bus.en0 & ~bus.flush;

    // Next-state for all stages and counters
    always_comb begin
        s0_d     = s0_q;
        s1_d     = s1_q;
        s2_d     = '0;
        stall_d  = stall_q;
        bubble_d = bubble_q;

        // stage 2: advance or bubble, never holds
        if (bus.en1) begin
            s2_d.c = s1_q.c;
            s2_d.t = s1_q.t;
            s2_d.v = s1_q.v;
        end

        // stage 1: hold while en1 is low (multi-cycle op), else stage 0 or bubble
        if (bus.en1) begin
            if (s0_pass) begin
                s1_d.c   = s0_q.c;
                s1_d.t   = s0_q.t;
                s1_d.alu = s0_q.alu;
                s1_d.v   = s0_q.v;
            end else begin
                s1_d = '0;
            end
        end

        // stage 0: flush beats everything, then load/bubble from decoder, else hold
        if (bus.flush) begin
            s0_d = '0;
        end else if (adv0) begin
            if (bus.in_valid) begin
                s0_d.a   = bus.in_A;
                s0_d.b   = bus.in_B;
                s0_d.c   = bus.in_C;
                s0_d.t   = bus.in_T;
                s0_d.alu = bus.in_ALU;
                s0_d.mr  = bus.in_MR;
                s0_d.v   = 1'b1;
            end else begin
                s0_d = '0;
            end
        end

        // saturating performance counters
        if (!bus.en0 && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNTW'(1);
        end
        // only bubbles created by stall/flush count, not ones from an empty stage 0
        if (bus.en1 && !s0_pass && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNTW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q     <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign bus.fetch_en   = adv0 & ~bus.flush;

    assign bus.A0         = s0_q.a;
    assign bus.B0         = s0_q.b;
    assign bus.C0         = s0_q.c;
    assign bus.T0         = s0_q.t;
    assign bus.ALU0       = s0_q.alu;
    assign bus.MR0        = s0_q.mr;
    assign bus.v0         = s0_q.v;
    assign bus.C1         = s1_q.c;
    assign bus.T1         = s1_q.t;
    assign bus.ALU1       = s1_q.alu;
    assign bus.v1         = s1_q.v;
    assign bus.C2         = s2_q.c;
    assign bus.T2         = s2_q.t;
    assign bus.v2         = s2_q.v;
    assign bus.stall_cnt  = stall_q;
    assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Testbench for pipe_stage_regs: directed scenarios plus randomized traffic, all
// compared against a per-stage reference model of the pipeline rules.
module tb_pipe_stage_regs;

    localparam int unsigned CW   = 6;
    localparam int unsigned BW   = 5;
    localparam int unsigned TW   = 7;
    localparam int unsigned ALUW = 4;
    localparam int unsigned CNTW = 5;
    localparam int unsigned VW   = 72;
    localparam logic [CNTW-1:0] CMAX = '1;
    localparam logic [ALUW-1:0] MUL  = 4'h3;

    typedef struct packed {
        logic [CW-1:0]   a;
        logic [BW-1:0]   b;
        logic [CW-1:0]   c;
        logic [TW-1:0]   t;
        logic [ALUW-1:0] alu;
        logic            mr;
        logic            v;
    } st_t;

    logic clk;
    logic rst;

    pipe_stage_regs_if #(.CW(CW), .BW(BW), .TW(TW), .ALUW(ALUW), .CNTW(CNTW)) bus ();

    pipe_stage_regs #(.CW(CW), .BW(BW), .TW(TW), .ALUW(ALUW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    st_t             m0, m1, m2;
    logic [CNTW-1:0] ms, mb;
    // bench copies of what is being driven
    st_t             cur_in;
    bit              cur_e0, cur_e1, cur_fl;

    function automatic logic [VW-1:0] dut_vec();
        return {bus.A0, bus.B0, bus.C0, bus.T0, bus.ALU0, bus.MR0, bus.v0,
                bus.C1, bus.T1, bus.ALU1, bus.v1,
                bus.C2, bus.T2, bus.v2, bus.stall_cnt, bus.bubble_cnt};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m0, m1.c, m1.t, m1.alu, m1.v, m2.c, m2.t, m2.v, ms, mb};
    endfunction

    // drive one cycle worth of inputs; unspecified fields are random
    task automatic drive(input bit e0, input bit e1, input bit fl, input bit vld,
                         input logic [CW-1:0] c, input logic [ALUW-1:0] alu);
        cur_e0 = e0;
        cur_e1 = e1;
        cur_fl = fl;
        cur_in.a   = CW'($urandom);
        cur_in.b   = BW'($urandom);
        cur_in.c   = c;
        cur_in.t   = TW'($urandom);
        cur_in.alu = alu;
        cur_in.mr  = 1'($urandom);
        cur_in.v   = vld;
        bus.in_A     = cur_in.a;
        bus.in_B     = cur_in.b;
        bus.in_C     = cur_in.c;
        bus.in_T     = cur_in.t;
        bus.in_ALU   = cur_in.alu;
        bus.in_MR    = cur_in.mr;
        bus.in_valid = vld;
        bus.en0      = e0;
        bus.en1      = e1;
        bus.flush    = fl;
    endtask

    // advance the model by the pipeline rules, then the clock; sample #1 after the edge
    task automatic tick();
        st_t n0, n1, n2, ld;
        if (rst) begin
            m0 = '0; m1 = '0; m2 = '0; ms = '0; mb = '0;
        end else begin
            ld = cur_in.v ? cur_in : '0;
            n2 = cur_e1 ? m1 : '0;
            if (!cur_e1)                 n1 = m1;
            else if (cur_e0 && !cur_fl)  n1 = m0;
            else                         n1 = '0;
            if (cur_fl)                  n0 = '0;
            else if (cur_e0 && cur_e1)   n0 = ld;
            else                         n0 = m0;
            if (!cur_e0 && ms != CMAX) ms = ms + CNTW'(1);
            if (cur_e1 && (!cur_e0 || cur_fl) && mb != CMAX) mb = mb + CNTW'(1);
            m0 = n0; m1 = n1; m2 = n2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1, 1, 0, 1, 6'h3f, 4'hf);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 0, 1, 6'h2a, 4'h5);
        tick();
        tick();
        n_cmp++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0", dut_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_flow();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1, 0, 1, CW'(k), 4'h1);
            tick();
            n_cmp++;
            if ({bus.C0, bus.C1, bus.C2} !== {CW'(k), CW'(k > 1 ? k - 1 : 0), CW'(k > 2 ? k - 2 : 0)}) begin
                n_fail++;
                $display("FAIL flow_c k=%0d got %0d/%0d/%0d want %0d/%0d/%0d", k,
                         bus.C0, bus.C1, bus.C2, k, (k > 1 ? k - 1 : 0), (k > 2 ? k - 2 : 0));
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL flow_state k=%0d got %h want %h", k, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (bus.v2 !== 1'b1 || bus.fetch_en !== 1'b1) begin
            n_fail++;
            $display("FAIL flow_v2 got v2=%b fetch_en=%b want 1/1", bus.v2, bus.fetch_en);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 1, 0, 1, 6'd4, 4'h2); tick();
        drive(1, 1, 0, 1, 6'd5, 4'h2); tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 1, 6'd9, 4'h2);
            tick();
            n_cmp++;
            if ({bus.C0, bus.v0, bus.C1, bus.v1, bus.fetch_en} !== {6'd5, 1'b1, 6'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold k=%0d got C0=%0d v0=%b C1=%0d v1=%b fe=%b want 5 1 0 0 0",
                         k, bus.C0, bus.v0, bus.C1, bus.v1, bus.fetch_en);
            end
        end
        n_cmp++;
        if (bus.stall_cnt !== 5'd2 || bus.bubble_cnt !== 5'd2) begin
            n_fail++;
            $display("FAIL stall_counts got %0d/%0d want 2/2", bus.stall_cnt, bus.bubble_cnt);
        end
    endtask

    task automatic test_multicycle();
        do_reset();
        drive(1, 1, 0, 1, 6'd1, MUL);  tick();
        drive(1, 1, 0, 1, 6'd2, 4'h0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 6'd11, 4'h7);
            tick();
            n_cmp++;
            if ({bus.C0, bus.C1, bus.ALU1, bus.v1, bus.T2, bus.v2} !==
                {6'd2, 6'd1, MUL, 1'b1, 7'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL mul_hold k=%0d got C0=%0d C1=%0d ALU1=%0d v1=%b T2=%0d v2=%b want 2 1 3 1 0 0",
                         k, bus.C0, bus.C1, bus.ALU1, bus.v1, bus.T2, bus.v2);
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL mul_state k=%0d got %h want %h", k, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (bus.stall_cnt !== 5'd3 || bus.bubble_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL mul_counts got %0d/%0d want 3/0", bus.stall_cnt, bus.bubble_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 1, 0, 1, 6'd7, 4'h1); tick();
        drive(1, 1, 1, 1, 6'd12, 4'h1);
        #1;
        n_cmp++;
        if (bus.fetch_en !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_fetch_en got %b want 0", bus.fetch_en);
        end
        tick();
        n_cmp++;
        if ({bus.v0, bus.C1, bus.v1, bus.bubble_cnt} !== {1'b0, 6'd0, 1'b0, 5'd1}) begin
            n_fail++;
            $display("FAIL flush_bubble got v0=%b C1=%0d v1=%b bub=%0d want 0 0 0 1",
                     bus.v0, bus.C1, bus.v1, bus.bubble_cnt);
        end
        drive(1, 1, 0, 1, 6'd8, 4'h1); tick();
        drive(1, 1, 0, 1, 6'd9, 4'h1); tick();
        drive(1, 0, 1, 1, 6'd13, 4'h1); tick();
        n_cmp++;
        if ({bus.v0, bus.C1, bus.v1, bus.v2, bus.bubble_cnt} !== {1'b0, 6'd8, 1'b1, 1'b0, 5'd1}) begin
            n_fail++;
            $display("FAIL flush_en1_low got v0=%b C1=%0d v1=%b v2=%b bub=%0d want 0 8 1 0 1",
                     bus.v0, bus.C1, bus.v1, bus.v2, bus.bubble_cnt);
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        for (int k = 1; k <= 34; k++) begin
            drive(0, 1, 0, 1, 6'd3, 4'h1);
            tick();
            if (k == 30 || k == 31 || k == 34) begin
                n_cmp++;
                if (bus.stall_cnt !== CNTW'(k > 31 ? 31 : k) || bus.bubble_cnt !== CNTW'(k > 31 ? 31 : k)) begin
                    n_fail++;
                    $display("FAIL saturate k=%0d got %0d/%0d want %0d", k,
                             bus.stall_cnt, bus.bubble_cnt, (k > 31 ? 31 : k));
                end
            end
        end
        rst = 1'b1;
        drive(0, 1, 0, 1, 6'd3, 4'h1);
        tick();
        rst = 1'b0;
        n_cmp++;
        if (dut_vec() !== '0 || bus.fetch_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midstall_reset got %h fe=%b want 0", dut_vec(), bus.fetch_en);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(39) == 0);
            drive($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(7) == 0,
                  $urandom_range(4) != 0, CW'($urandom), ALUW'($urandom));
            #1;
            n_cmp++;
            if (bus.fetch_en !== (cur_e0 & cur_e1 & ~cur_fl)) begin
                n_fail++;
                $display("FAIL rand_fetch_en k=%0d got %b want %b", k, bus.fetch_en,
                         cur_e0 & cur_e1 & ~cur_fl);
            end
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL rand_state k=%0d got %h want %h", k, dut_vec(), model_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0 = '0; m1 = '0; m2 = '0; ms = '0; mb = '0;
        drive(0, 0, 0, 0, '0, '0);
        test_reset();
        test_flow();
        test_stall();
        test_multicycle();
        test_flush();
        test_saturate_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
